// File: rtl/modulo_teclado.sv
// Note keypad encoder: 2-flop sync, lowest-index priority encode, debounce FSM, latched TOM/ABCD.
// Define MODULO_TECLADO_REPEAT_EN to re-pulse Valido every REPEAT cycles while a key stays held.
module modulo_teclado #(
   parameter int DEBOUNCE = 16,
   parameter int REPEAT   = 256
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic [7:0] Teclas,
   input  logic       Sustenido,
   input  logic       Limpa,
   output logic       TOM,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       Valido
);
   localparam int            CW      = $clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] CNT_REL = CW'(DEBOUNCE - 2);

   typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

   logic [7:0]    tec_s1_q, tec_s2_q;
   logic          sus_s1_q, sus_s2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cap_q, cap_d;
   logic [3:0]    code_q, code_d;
   logic          tom_q, tom_d;
   logic          valido_q, valido_d;
   logic [3:0]    cand;
   logic          accept;
   logic          repeat_pulse;

   always_comb begin
      cand = 4'd0;
      for (int i = 7; i >= 0; i--)
         if (tec_s2_q[i]) cand = 4'(i + 1);
   end

   // cand == cap_q here implies a nonzero key, since DEB always holds a captured key
   assign accept = (state_q == DEB) && (cand == cap_q) && (cnt_q == CNT_ACC);

`ifdef MODULO_TECLADO_REPEAT_EN
   localparam int            RW      = $clog2(REPEAT);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT - 1);

   logic [RW-1:0] rpt_q, rpt_d;

   always_comb begin
      rpt_d = rpt_q;
      if (Limpa || accept)
         rpt_d = '0;
      else if (state_q == HELD && cand == cap_q)
         rpt_d = (rpt_q == RPT_MAX) ? '0 : rpt_q + 1'b1;
   end

   assign repeat_pulse = !Limpa && (state_q == HELD) && (cand == cap_q) && (rpt_q == RPT_MAX);

   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) rpt_q <= '0;
      else          rpt_q <= rpt_d;
`else
   // REPEAT is legal only >= 2, so this folds to 0 without the repeat counter
   assign repeat_pulse = (REPEAT < 0);
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         tec_s1_q <= '0;
         tec_s2_q <= '0;
         sus_s1_q <= 1'b0;
         sus_s2_q <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         cap_q    <= '0;
         code_q   <= '0;
         tom_q    <= 1'b0;
         valido_q <= 1'b0;
      end else begin
         tec_s1_q <= Teclas;
         tec_s2_q <= tec_s1_q;
         sus_s1_q <= Sustenido;
         sus_s2_q <= sus_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cap_q    <= cap_d;
         code_q   <= code_d;
         tom_q    <= tom_d;
         valido_q <= valido_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      case (state_q)
         IDLE:
            if (!Limpa && cand != 4'd0) begin
               cap_d   = cand;
               cnt_d   = CW'(1);
               state_d = DEB;
            end
         DEB:
            if (Limpa) begin
               state_d = REL;
               cnt_d   = '0;
            end else if (cand == 4'd0) begin
               state_d = IDLE;
            end else if (cand != cap_q) begin
               cap_d = cand;
               cnt_d = CW'(1);
            end else if (cnt_q == CNT_ACC) begin
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         HELD:
            if (Limpa || cand != cap_q) begin
               state_d = REL;
               cnt_d   = '0;
            end
         REL:
            // any key during release restarts the full-release wait
            if (!Limpa) begin
               if (cand != 4'd0)          cnt_d   = '0;
               else if (cnt_q == CNT_REL) state_d = IDLE;
               else                       cnt_d   = cnt_q + 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tom_d    = tom_q;
      code_d   = code_q;
      valido_d = 1'b0;
      if (Limpa) begin
         tom_d  = 1'b0;
         code_d = 4'd0;
      end else if (accept) begin
         tom_d    = sus_s2_q;
         code_d   = cap_q;
         valido_d = 1'b1;
      end else if (repeat_pulse) begin
         valido_d = 1'b1;
      end
   end

   assign TOM          = tom_q;
   assign {A, B, C, D} = code_q;
   assign Valido       = valido_q;
endmodule
